// File: rtl/spi_master_arb.sv
// Two-requester, 16-bit, mode-0, MSB-first SPI master with round-robin arbitration.
// Define SPI_ARB_FIXED_PRIO_EN to make requester 0 win every tie instead.
module spi_master_arb #(
  parameter int CLK_DIV = 4,
  parameter int WORD_W  = 16
) (
  input  logic              sclk,
  input  logic              rst_n,
  input  logic [1:0]        req,
  input  logic [WORD_W-1:0] wdata0,
  input  logic [WORD_W-1:0] wdata1,
  output logic [1:0]        gnt,
  output logic [1:0]        done,
  output logic [WORD_W-1:0] rdata,
  output logic              busy,
  output logic              spi_clk,
  output logic              spi_cs_n,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int               CNT_W    = $clog2(CLK_DIV + 1);
  localparam logic [CNT_W-1:0] DIV_FULL = CNT_W'(CLK_DIV);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] DIV_ONE  = CNT_W'(1);
  localparam logic [4:0]       LAST_BIT = 5'(WORD_W - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;

  state_t            state, state_d;
  logic [CNT_W-1:0]  div_cnt, div_cnt_d;
  logic [4:0]        bit_cnt, bit_cnt_d;
  logic [WORD_W-1:0] tx_sr, tx_sr_d;
  logic [WORD_W-1:0] rx_sr, rx_sr_d;
  logic [WORD_W-1:0] rdata_d;
  logic              cur, cur_d;
  logic              last, last_d;
  logic [1:0]        gnt_d, done_d;
  logic              busy_d, spi_clk_d, spi_cs_n_d, spi_mosi_d;
  logic              win, tick, start;

`ifdef SPI_ARB_FIXED_PRIO_EN
  assign win = ~req[0];
`else
  assign win = (req == 2'b11) ? ~last : req[1];
`endif

  always_comb begin
    // NOTE: every target gets its default first, so no path through the case leaves
    // a variable unassigned and no latch can be inferred.
    state_d    = state;
    div_cnt_d  = div_cnt;
    bit_cnt_d  = bit_cnt;
    tx_sr_d    = tx_sr;
    rx_sr_d    = rx_sr;
    rdata_d    = rdata;
    cur_d      = cur;
    last_d     = last;
    gnt_d      = 2'b00;
    done_d     = 2'b00;
    busy_d     = busy;
    spi_clk_d  = spi_clk;
    spi_cs_n_d = spi_cs_n;
    spi_mosi_d = spi_mosi;
    tick       = (div_cnt == '0);
    start      = 1'b0;

    case (state)
      S_IDLE: start = |req;

      S_SETUP: begin
        spi_cs_n_d = 1'b0;
        spi_mosi_d = tx_sr[WORD_W-1];
        if (tick) begin
          // The SETUP->SHIFT transition is the first rising SPI edge, so it samples MISO.
          spi_clk_d = 1'b1;
          rx_sr_d   = {rx_sr[WORD_W-2:0], spi_miso};
          bit_cnt_d = '0;
          div_cnt_d = DIV_LAST;
          state_d   = S_SHIFT;
        end else begin
          div_cnt_d = div_cnt - DIV_ONE;
        end
      end

      S_SHIFT: begin
        if (tick) begin
          spi_clk_d = ~spi_clk;
          div_cnt_d = DIV_LAST;
          if (!spi_clk) begin
            rx_sr_d = {rx_sr[WORD_W-2:0], spi_miso};
          end else begin
            tx_sr_d    = {tx_sr[WORD_W-2:0], 1'b0};
            spi_mosi_d = tx_sr[WORD_W-2];
            bit_cnt_d  = bit_cnt + 5'd1;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt_d = '0;
              state_d   = S_HOLD;
            end
          end
        end else begin
          div_cnt_d = div_cnt - DIV_ONE;
        end
      end

      S_HOLD: begin
        if (tick) begin
          spi_cs_n_d   = 1'b1;
          done_d[cur]  = 1'b1;
          rdata_d      = rx_sr;
          div_cnt_d    = DIV_LAST;
          state_d      = S_GAP;
        end else begin
          div_cnt_d = div_cnt - DIV_ONE;
        end
      end

      S_GAP: begin
        if (tick) begin
          busy_d    = 1'b0;
          div_cnt_d = DIV_FULL;
          state_d   = S_IDLE;
          // Arbitrate on the same edge that returns to IDLE, keeping back-to-back words tight.
          start     = |req;
        end else begin
          div_cnt_d = div_cnt - DIV_ONE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (start) begin
      gnt_d[win] = 1'b1;
      tx_sr_d    = win ? wdata1 : wdata0;
      cur_d      = win;
      last_d     = win;
      busy_d     = 1'b1;
      div_cnt_d  = DIV_FULL;
      bit_cnt_d  = '0;
      state_d    = S_SETUP;
    end
  end

  always_ff @(posedge sclk) begin
    // NOTE: non-blocking assignments make every register sample pre-edge values,
    // independent of statement order.
    if (!rst_n) begin
      state    <= S_IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      rdata    <= '0;
      cur      <= 1'b0;
      last     <= 1'b1;
      gnt      <= 2'b00;
      done     <= 2'b00;
      busy     <= 1'b0;
      spi_clk  <= 1'b0;
      spi_cs_n <= 1'b1;
      spi_mosi <= 1'b0;
    end else begin
      state    <= state_d;
      div_cnt  <= div_cnt_d;
      bit_cnt  <= bit_cnt_d;
      tx_sr    <= tx_sr_d;
      rx_sr    <= rx_sr_d;
      rdata    <= rdata_d;
      cur      <= cur_d;
      last     <= last_d;
      gnt      <= gnt_d;
      done     <= done_d;
      busy     <= busy_d;
      spi_clk  <= spi_clk_d;
      spi_cs_n <= spi_cs_n_d;
      spi_mosi <= spi_mosi_d;
    end
  end

endmodule

// File: doc/spi_master_arb.md
# spi_master_arb

Two-requester SPI master that shares one 16-bit SPI link between two on-chip clients. It performs full-duplex 16-bit mode-0 transfers toward the team's SPI slave. Each transfer is granted by round-robin arbitration, shifted MSB-first with a programmable SCLK divider, and returned to the winning requester with a done pulse. It sits between the command/control logic and the board-level SPI pins.

## Interface
- `CLK_DIV`, default 4: SPI half-period in system clocks; legal range is ≥1.
- `WORD_W`, default 16: transfer width in bits; fixed at 16 for this link.
- `sclk` in, 1 bit: system clock; all logic is on the rising edge.
- `rst_n` in, 1 bit: reset, synchronous and active-low.
- `req` in, 2 bits: level request per requester; index 0 and index 1.
- `wdata0`, `wdata1` in, 16 bits each: transmit word, sampled on that requester's grant cycle.
- `gnt` out, 2 bits: one-cycle pulse marking the cycle the word is latched.
- `done` out, 2 bits: one-cycle pulse; `rdata` is valid in the same cycle.
- `rdata` out, 16 bits: last received word, held until the next `done`.
- `busy` out, 1 bit: high from the grant cycle until the block is back in IDLE.
- `spi_clk` out, 1 bit: SPI clock, CPOL=0.
- `spi_cs_n` out, 1 bit: chip select, active-low.
- `spi_mosi` out, 1 bit: serial data out, MSB first.
- `spi_miso` in, 1 bit: serial data in; it is already synchronous to `sclk`.

## Operation
- Reset values (`rst_n`=0 at an edge):
  - `spi_cs_n`=1, `spi_clk`=0, `spi_mosi`=0.
  - `gnt`=0, `done`=0, `busy`=0, `rdata`=0.
  - State is IDLE and the round-robin pointer `last`=1, so requester 0 wins the first tie.
- IDLE:
  - If `req`≠0, pick a winner:
    - if only one bit is set, that requester wins;
    - if both are set, the requester ≠ `last` wins.
  - Then: pulse `gnt[w]`, latch `wdataw` into the shift register, set `last`=w, set `busy`=1, and go to SETUP.
- SETUP:
  - `spi_cs_n`=0 and `spi_mosi`=bit 15 from the first SETUP cycle.
  - After CLK_DIV cycles, raise `spi_clk` and go to SHIFT.
- SHIFT:
  - `spi_clk` toggles every CLK_DIV cycles.
  - On each rising edge, shift `spi_miso` into the rx register.
  - On each falling edge, drive the next tx bit on `spi_mosi`.
  - The transfer has 16 rising and 16 falling edges. The 16th falling edge leaves `spi_clk`=0 and the state goes to HOLD.
- HOLD: after CLK_DIV cycles, set `spi_cs_n`=1, pulse `done[w]`, load `rdata` with the rx word, and go to GAP.
- GAP: after CLK_DIV cycles, clear `busy` and return to IDLE.
- `req` is ignored outside IDLE.
- A requester holding `req` after its `done` gets a new transfer, subject to arbitration.
- A `req` drop before grant cancels the request with no side effects.

## Timing
- Grant at edge t gives:
  - `spi_cs_n` low at t+1;
  - first `spi_clk` rise at t+1+CLK_DIV;
  - last fall at t+1+32·CLK_DIV;
  - `spi_cs_n` high and `done` at t+1+33·CLK_DIV;
  - IDLE at t+1+34·CLK_DIV, where the next grant may occur in the same cycle.
- Back-to-back cycle period is 34·CLK_DIV+1 sclk cycles. `spi_cs_n` stays high for ≥CLK_DIV+1 cycles between words.
- MOSI is stable for CLK_DIV cycles before and after every rising `spi_clk`.
- CLK_DIV=1 is legal: `spi_clk` = sclk/2.
- The divide counter is ⌈log2(CLK_DIV+1)⌉ bits and the bit counter is 5 bits. Both reload on every state change, with no wrap across states.
- Reset mid-transfer: at the next edge `spi_cs_n`=1 and `spi_clk`=0. No `done` is issued and the aborted word is lost.
- `gnt` and `done` never assert in the same cycle, and never for both indices at once.

## Configuration
- `SPI_ARB_FIXED_PRIO_EN` defined: fixed priority, where requester 0 always wins a tie; `last` is not used for the decision.
- Not defined: round-robin as described above.
- All timing is identical in both builds.

## Test plan
- Single request: `req`=01, `wdata0`=16'hA5C3, `spi_miso` looped from `spi_mosi`, CLK_DIV=4 -> `gnt`=01 at t, `spi_cs_n` low t+1..t+132, 16 `spi_clk` rises, `done`=01 at t+133, `rdata`=16'hA5C3.
- Tie, round-robin: `req`=11 held for three words -> grants 0,1,0. With `SPI_ARB_FIXED_PRIO_EN` -> grants 0,0,0.
- MISO capture: slave drives 16'hFFFF while `wdata1`=16'h0000 -> `spi_mosi` is low for all bits, `done`=10, `rdata`=16'hFFFF.
- Request during transfer: `req`=10 asserted mid-SHIFT of a requester-0 word -> no `gnt` until IDLE; `gnt`=10 exactly 34·CLK_DIV+1 cycles after the first grant.
- Reset abort: `rst_n`=0 for one cycle after the 7th rising `spi_clk` -> next cycle `spi_cs_n`=1, `spi_clk`=0, `busy`=0, no `done`; a subsequent `req`=01 completes normally.
- CLK_DIV=1: one word, `wdata0`=16'h8001 -> `spi_clk` toggles every cycle, `done` at t+34.
